// File: rtl/opentrig_pkg.sv
// opentrig_pkg -- shared definitions for the trigger readout path.
//   Frame constants, 128-bit frame field positions, default widths,
//   scheduler state encoding and the frame builder used by readout_sched.
package opentrig_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ID_W   = 16;
  localparam int DEF_CYC_W  = 48;
  localparam int DEF_DATA_W = 24;

  localparam logic [7:0] FRAME_SOF = 8'h7E;
  localparam logic [7:0] FRAME_EOF = 8'h7D;

  // LSB positions of each field inside the 128-bit frame
  localparam int FR_SOF_LSB  = 120;
  localparam int FR_ID_LSB   = 104;
  localparam int FR_RSV_LSB  = 88;   // 16 reserved bits, always zero
  localparam int FR_CYC_LSB  = 40;
  localparam int FR_PAD_LSB  = 32;
  localparam int FR_DATA_LSB = 8;
  localparam int FR_EOF_LSB  = 0;

  localparam logic [127:0] IDLE_FRAME = {FRAME_SOF, 112'h0, FRAME_EOF};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_READING = 2'd2,
    ST_POP     = 2'd3
  } rs_state_e;

  function automatic logic [127:0] build_frame(input logic [15:0] id,
                                               input logic [47:0] cyc,
                                               input logic [7:0]  pad,
                                               input logic [23:0] data);
    logic [127:0] f;
    f = '0;
    f[FR_SOF_LSB  +: 8]  = FRAME_SOF;
    f[FR_ID_LSB   +: 16] = id;
    f[FR_CYC_LSB  +: 48] = cyc;
    f[FR_PAD_LSB  +: 8]  = pad;
    f[FR_DATA_LSB +: 24] = data;
    f[FR_EOF_LSB  +: 8]  = FRAME_EOF;
    return f;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo -- synchronous single-clock FIFO holding captured events.
//   clk/reset      : clock, synchronous active-high reset (pointers only)
//   push/din       : write request and data (accepted when not full, or
//                    when full with a simultaneous pop)
//   pop/dout       : read request; dout is the current head (show-ahead)
//   full/empty     : status, pointers carry one extra wrap bit
//   count          : number of stored entries
module event_fifo
  import opentrig_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_ID_W + DEF_CYC_W + DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q, cnt_q;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/readout_sched.sv
// readout_sched -- buffers trigger events and presents them one frame at a
// time to an SPI shifter, with an active-low interrupt to the MCU.
//   sampling_clk/reset : clock, synchronous active-high reset
//   evt_*              : captured event (strobe + ID, timestamp, data)
//   rd_active/rd_done  : chip-select level and "128 bits shifted" pulse
//   frame              : 128-bit frame for the shifter (registered)
//   interrupt          : active-low service request
//   fill / ovf_count   : buffered frame count / saturating drop count
// Build option: READOUT_OVF_PAD_EN places ovf_count (sampled when the
// frame is loaded) into the pad byte; otherwise the pad byte is zero.
module readout_sched
  import opentrig_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ID_W   = DEF_ID_W,
  parameter int CYC_W  = DEF_CYC_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    sampling_clk,
  input  logic                    reset,
  input  logic                    evt_strobe,
  input  logic [ID_W-1:0]         evt_id,
  input  logic [CYC_W-1:0]        evt_cycle,
  input  logic [DATA_W-1:0]       evt_data,
  input  logic                    rd_active,
  input  logic                    rd_done,
  output logic [127:0]            frame,
  output logic                    interrupt,
  output logic [$clog2(DEPTH):0]  fill,
  output logic [7:0]              ovf_count
);
  localparam int EW = ID_W + CYC_W + DATA_W;

  rs_state_e     state_q;
  logic [127:0]  frame_q;
  logic          int_q;
  logic          done_q;
  logic [7:0]    ovf_q;

  logic [EW-1:0] head;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    pad;
  logic [127:0]  head_frame;

  assign pop = (state_q == ST_POP);

  event_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (sampling_clk),
    .reset (reset),
    .push  (evt_strobe),
    .din   ({evt_id, evt_cycle, evt_data}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill)
  );

`ifdef READOUT_OVF_PAD_EN
  assign pad = ovf_q;
`else
  assign pad = 8'h00;
`endif

  assign head_frame = build_frame(16'(head[EW-1 -: ID_W]),
                                  48'(head[DATA_W +: CYC_W]),
                                  pad,
                                  24'(head[DATA_W-1:0]));

  always_ff @(posedge sampling_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      frame_q <= IDLE_FRAME;
      int_q   <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= '0;
    end else begin
      // A pop frees a slot in the same cycle, so only full-without-pop drops
      if (evt_strobe && fifo_full && !pop && ovf_q != 8'hFF)
        ovf_q <= ovf_q + 8'd1;

      case (state_q)
        ST_IDLE: begin
          // rd_active high here means the MCU is shifting the idle frame
          if (!fifo_empty && !rd_active) begin
            state_q <= ST_PRESENT;
            frame_q <= head_frame;
            int_q   <= 1'b0;
          end
        end
        ST_PRESENT: begin
          // int_q still high means we arrived from POP and the new head
          // has not been latched yet; load it before inviting a read.
          if (int_q) begin
            frame_q <= head_frame;
            int_q   <= 1'b0;
          end else if (rd_active) begin
            state_q <= ST_READING;
            int_q   <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_READING: begin
          if (rd_done) done_q <= 1'b1;
          if (!rd_active) begin
            if (done_q || rd_done) begin
              state_q <= ST_POP;
            end else begin
              // aborted read: same head stays in frame_q
              state_q <= ST_PRESENT;
              int_q   <= 1'b0;
            end
          end
        end
        ST_POP: begin
          done_q <= 1'b0;
          // fill still counts the head being popped; a push this cycle is
          // always accepted because a slot is being freed
          if (fill > 1 || evt_strobe) begin
            state_q <= ST_PRESENT;
          end else begin
            state_q <= ST_IDLE;
            frame_q <= IDLE_FRAME;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign frame     = frame_q;
  assign interrupt = int_q;
  assign ovf_count = ovf_q;

endmodule

// File: tb/tb_readout_sched.sv
module tb_readout_sched;
  logic          clk = 1'b0;
  logic          reset;
  logic          evt_strobe;
  logic [15:0]   evt_id;
  logic [47:0]   evt_cycle;
  logic [23:0]   evt_data;
  logic          rd_active;
  logic          rd_done;
  logic [127:0]  frame;
  logic          interrupt;
  logic [3:0]    fill;
  logic [7:0]    ovf_count;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [127:0] IDLE_F = {8'h7E, 112'h0, 8'h7D};

  readout_sched #(.DEPTH(8), .ID_W(16), .CYC_W(48), .DATA_W(24)) dut (
    .sampling_clk (clk),
    .reset        (reset),
    .evt_strobe   (evt_strobe),
    .evt_id       (evt_id),
    .evt_cycle    (evt_cycle),
    .evt_data     (evt_data),
    .rd_active    (rd_active),
    .rd_done      (rd_done),
    .frame        (frame),
    .interrupt    (interrupt),
    .fill         (fill),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [15:0] id, input logic [47:0] cyc,
                                      input logic [7:0] pad, input logic [23:0] data);
    return {8'h7E, id, 16'h0000, cyc, pad, data, 8'h7D};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input logic [15:0] id, input logic [47:0] cyc, input logic [23:0] data);
    evt_strobe = 1'b1; evt_id = id; evt_cycle = cyc; evt_data = data;
    tick;
    evt_strobe = 1'b0;
  endtask

  // leaves the DUT in POP (done) or back in PRESENT (abort)
  task automatic do_read(input bit done);
    rd_active = 1'b1; tick; tick;
    if (done) begin rd_done = 1'b1; tick; rd_done = 1'b0; end
    tick;
    rd_active = 1'b0; tick;
  endtask

  logic [7:0]   exp_pad;
  logic [127:0] held;

  initial begin
    reset = 1'b1; evt_strobe = 1'b0; evt_id = '0; evt_cycle = '0; evt_data = '0;
    rd_active = 1'b0; rd_done = 1'b0;
    tick; tick;
    reset = 1'b0;
    chk("rst_fill", fill, 0);
    chk("rst_int", interrupt, 1);
    chk("rst_frame", frame, IDLE_F);
    chk("rst_ovf", ovf_count, 0);

    // single event: interrupt low two edges after the strobe
    push_evt(16'h0001, 48'h123456, 24'hABCDEF);
    chk("one_fill", fill, 1);
    chk("one_int_c1", interrupt, 1);
    tick;
    chk("one_int_c2", interrupt, 0);
    chk("one_frame", frame, 128'h7E_0001_0000_000000123456_00_ABCDEF_7D);
    do_read(1'b1);
    tick;
    chk("one_fill_end", fill, 0);
    chk("one_int_end", interrupt, 1);
    chk("one_frame_end", frame, IDLE_F);

    // three events read out in order
    for (int k = 0; k < 3; k++)
      push_evt(16'h0011 * 16'(k + 1), 48'h1000 + 48'(k), 24'h0A0000 + 24'(k));
    chk("t3_fill", fill, 3);
    chk("t3_int", interrupt, 0);
    chk("t3_frame0", frame, mk(16'h0011, 48'h1000, 8'h00, 24'h0A0000));
    for (int k = 0; k < 3; k++) begin
      do_read(1'b1);
      chk("t3_pop_int", interrupt, 1);
      tick;
      chk("t3_fill_dec", fill, 4'(2 - k));
      if (k < 2) begin
        chk("t3_int_gap", interrupt, 1);
        tick;
        chk("t3_int_low", interrupt, 0);
        chk("t3_frame_next", frame,
            mk(16'h0011 * 16'(k + 2), 48'h1000 + 48'(k + 1), 8'h00, 24'h0A0000 + 24'(k + 1)));
      end else begin
        chk("t3_frame_idle", frame, IDLE_F);
      end
    end

    // aborted read re-presents the same frame; stray rd_done ignored
    push_evt(16'h0055, 48'h55, 24'h000055);
    tick;
    do_read(1'b0);
    chk("abort_int", interrupt, 0);
    chk("abort_frame", frame, mk(16'h0055, 48'h55, 8'h00, 24'h000055));
    chk("abort_fill", fill, 1);
    rd_done = 1'b1; tick; rd_done = 1'b0; tick;
    chk("stray_done_fill", fill, 1);
    chk("stray_done_int", interrupt, 0);
    do_read(1'b1);
    tick;
    chk("abort_drain", fill, 0);

    // push during READING keeps the frame bit-stable
    push_evt(16'h0066, 48'h66, 24'h000066);
    tick;
    held = mk(16'h0066, 48'h66, 8'h00, 24'h000066);
    rd_active = 1'b1; tick;
    push_evt(16'h0077, 48'h77, 24'h000077);
    chk("rdpush_frame_a", frame, held);
    chk("rdpush_fill", fill, 2);
    rd_done = 1'b1; tick; rd_done = 1'b0;
    chk("rdpush_frame_b", frame, held);
    rd_active = 1'b0; tick;
    chk("rdpush_frame_c", frame, held);
    tick; tick;
    chk("rdpush_next", frame, mk(16'h0077, 48'h77, 8'h00, 24'h000077));
    chk("rdpush_fill2", fill, 1);
    do_read(1'b1);
    tick;
    chk("rdpush_drain", fill, 0);

    // overflow: 10 strobes into DEPTH=8 while the MCU holds chip-select
    rd_active = 1'b1;
    for (int k = 0; k < 10; k++)
      push_evt(16'h0100 + 16'(k), 48'h0, 24'h0);
    chk("ovf_fill", fill, 8);
    chk("ovf_count", ovf_count, 2);
    chk("ovf_int_idle", interrupt, 1);
    chk("ovf_idle_frame", frame, IDLE_F);
`ifdef READOUT_OVF_PAD_EN
    exp_pad = 8'h02;
`else
    exp_pad = 8'h00;
`endif
    rd_active = 1'b0; tick;
    chk("ovf_frame", frame, mk(16'h0100, 48'h0, exp_pad, 24'h0));
    chk("ovf_pad", frame[39:32], exp_pad);

    // reset with a simultaneous strobe into a full FIFO: nothing counted
    reset = 1'b1; evt_strobe = 1'b1; tick;
    reset = 1'b0; evt_strobe = 1'b0;
    chk("rststb_ovf", ovf_count, 0);
    chk("rststb_fill", fill, 0);

    // reset in the middle of a read with four buffered frames
    for (int k = 0; k < 4; k++)
      push_evt(16'h0200 + 16'(k), 48'h0, 24'h0);
    chk("mid_fill4", fill, 4);
    rd_active = 1'b1; tick;
    chk("mid_reading_int", interrupt, 1);
    reset = 1'b1; tick; reset = 1'b0;
    chk("mid_fill", fill, 0);
    chk("mid_int", interrupt, 1);
    chk("mid_frame", frame, IDLE_F);
    rd_done = 1'b1; tick; rd_done = 1'b0;
    rd_active = 1'b0; tick; tick;
    chk("mid_after_fill", fill, 0);
    chk("mid_after_int", interrupt, 1);
    chk("mid_after_frame", frame, IDLE_F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
